execution_unit_pipe: RTL and testbench

Parametrised successor to the RV32I `execution` unit: a registered integer execution stage with valid/ready handshakes on both sides. It executes base R-type and I-type ALU operations plus the M extension. MUL* completes in one cycle; DIV/REM use an iterative restoring divider. It sits between decode/register-read and writeback and honours the global `system_stall`.

---
 rtl/execution_unit_pipe.sv | 195 +++++++++++++++++++
 tb/tb_execution_unit_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_unit_pipe.sv
// execution_unit_pipe: registered RV32I + M integer execution stage.
// Single-cycle ALU/MUL/special-case divides; iterative restoring divider for
// DIV/DIVU/REM/REMU. Valid/ready on both sides, frozen by system_stall.
module execution_unit_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int IMM_WIDTH   = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            instruction_type,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic [DATA_WIDTH-1:0] data_src1,
  input  logic [DATA_WIDTH-1:0] data_src2,
  input  logic                  system_stall,
  output logic [DATA_WIDTH-1:0] Execution_Result,
  output logic                  Result_valid,
  input  logic                  result_ready,
  output logic                  illegal,
  output logic                  busy
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;
  localparam int         CNT_W   = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  // Two's-complement negate when requested (magnitude conversion and sign fix-up).
  function automatic logic [DATA_WIDTH-1:0] apply_sign(input logic [DATA_WIDTH-1:0] mag,
                                                       input logic neg);
    return neg ? -mag : mag;
  endfunction

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // ---- stage p0: decode, operand select, single-cycle datapath ----
  logic                         is_r_p0, is_i_p0, is_base_p0, is_mext_p0;
  logic                         sub_p0, sra_sel_p0;
  logic [DATA_WIDTH-1:0]        imm_ext_p0, opb_p0;
  logic signed [DATA_WIDTH-1:0] src1_s_p0, opb_s_p0;
  logic [SHAMT_WIDTH-1:0]       shamt_p0;
  logic [DATA_WIDTH-1:0]        sra_p0, alu_p0;
  logic                         mul_sa_p0, mul_sb_p0;
  logic signed [2*DATA_WIDTH-1:0] mul_a_p0, mul_b_p0, mul_p_p0;
  logic [DATA_WIDTH-1:0]        mul_res_p0, spec_res_p0, single_res_p0;
  logic                         single_ill_p0;
  logic                         div_signed_p0, div_zero_p0, div_ovf_p0, start_div_p0;
  logic                         accept_p0;

  assign is_r_p0    = (instruction_type == OP_R);
  assign is_i_p0    = (instruction_type == OP_I);
  assign imm_ext_p0 = {{(DATA_WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate};
  assign opb_p0     = is_r_p0 ? data_src2 : imm_ext_p0;
  assign src1_s_p0  = data_src1;
  assign opb_s_p0   = opb_p0;
  assign shamt_p0   = opb_p0[SHAMT_WIDTH-1:0];
  assign sra_p0     = src1_s_p0 >>> shamt_p0;

  // R-type funct7=0100000 selects SUB/SRA; I-type picks SRAI with immediate[10].
  assign sub_p0     = is_r_p0 & (funct7 == F7_ALT);
  assign sra_sel_p0 = is_r_p0 ? (funct7 == F7_ALT) : immediate[10];
  assign is_base_p0 = is_i_p0 |
                      (is_r_p0 & ((funct7 == F7_BASE) |
                                  ((funct7 == F7_ALT) & ((funct3 == 3'b000) | (funct3 == 3'b101)))));
  assign is_mext_p0 = is_r_p0 & (funct7 == F7_MEXT);

  // Base integer ALU.
  always_comb begin
    alu_p0 = '0;
    case (funct3)
      3'b000:  alu_p0 = sub_p0 ? (data_src1 - opb_p0) : (data_src1 + opb_p0);
      3'b001:  alu_p0 = data_src1 << shamt_p0;
      3'b010:  alu_p0 = {{(DATA_WIDTH-1){1'b0}}, (src1_s_p0 < opb_s_p0)};
      3'b011:  alu_p0 = {{(DATA_WIDTH-1){1'b0}}, (data_src1 < opb_p0)};
      3'b100:  alu_p0 = data_src1 ^ opb_p0;
      3'b101:  alu_p0 = sra_sel_p0 ? sra_p0 : (data_src1 >> shamt_p0);
      3'b110:  alu_p0 = data_src1 | opb_p0;
      default: alu_p0 = data_src1 & opb_p0;
    endcase
  end

  // One shared 2W-bit signed multiplier; operand extension picks the signedness.
  assign mul_sa_p0  = (funct3 != 3'b011) & data_src1[DATA_WIDTH-1];
  assign mul_sb_p0  = ((funct3 == 3'b000) | (funct3 == 3'b001)) & opb_p0[DATA_WIDTH-1];
  assign mul_a_p0   = {{DATA_WIDTH{mul_sa_p0}}, data_src1};
  assign mul_b_p0   = {{DATA_WIDTH{mul_sb_p0}}, opb_p0};
  assign mul_p_p0   = mul_a_p0 * mul_b_p0;
  assign mul_res_p0 = (funct3[1:0] == 2'b00) ? mul_p_p0[DATA_WIDTH-1:0]
                                             : mul_p_p0[2*DATA_WIDTH-1:DATA_WIDTH];

  // Divide special cases resolve in one cycle and never start the iterator.
  assign div_signed_p0 = ~funct3[0];
  assign div_zero_p0   = (opb_p0 == '0);
  assign div_ovf_p0    = div_signed_p0 & (data_src1 == MOST_NEG) & (opb_p0 == '1);
  assign spec_res_p0   = div_zero_p0 ? (funct3[1] ? data_src1 : '1)
                                     : (funct3[1] ? '0 : data_src1);
  assign start_div_p0  = is_mext_p0 & funct3[2] & ~div_zero_p0 & ~div_ovf_p0;

  // Result for everything that completes in the accept cycle.
  always_comb begin
    single_res_p0 = '0;
    single_ill_p0 = 1'b0;
    if (is_mext_p0)      single_res_p0 = funct3[2] ? spec_res_p0 : mul_res_p0;
    else if (is_base_p0) single_res_p0 = alu_p0;
    else                 single_ill_p0 = 1'b1;
  end

  assign in_ready  = (state_q == S_IDLE) & ~system_stall & (~Result_valid | result_ready);
  assign accept_p0 = in_valid & in_ready;
  assign busy      = (state_q == S_DIV);

  // ---- stage p1: restoring divider state ----
  logic [DATA_WIDTH-1:0] rem_p1, quo_p1, dvsr_p1;
  logic                  neg_q_p1, neg_r_p1, is_rem_p1;
  logic [DATA_WIDTH:0]   shifted_p1, diff_p1;
  logic [DATA_WIDTH-1:0] rem_nx_p1, quo_nx_p1, div_res_p1;
  logic                  div_done_p1;

  assign shifted_p1  = {rem_p1, quo_p1[DATA_WIDTH-1]};
  assign diff_p1     = shifted_p1 - {1'b0, dvsr_p1};
  assign rem_nx_p1   = diff_p1[DATA_WIDTH] ? shifted_p1[DATA_WIDTH-1:0] : diff_p1[DATA_WIDTH-1:0];
  assign quo_nx_p1   = {quo_p1[DATA_WIDTH-2:0], ~diff_p1[DATA_WIDTH]};
  assign div_res_p1  = is_rem_p1 ? apply_sign(rem_nx_p1, neg_r_p1)
                                 : apply_sign(quo_nx_p1, neg_q_p1);
  assign div_done_p1 = (state_q == S_DIV) & ~system_stall & (cnt_q == CNT_LAST);

  // Next-state: enter DIV on a non-special divide, leave on the last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_p0 & start_div_p0) state_d = S_DIV;
      default: if (div_done_p1) state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Iteration counter and output slot (result, valid, illegal).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q            <= '0;
      Execution_Result <= '0;
      Result_valid     <= 1'b0;
      illegal          <= 1'b0;
    end else if (accept_p0) begin
      if (start_div_p0) begin
        cnt_q        <= '0;
        Result_valid <= 1'b0;
        illegal      <= 1'b0;
      end else begin
        Execution_Result <= single_res_p0;
        Result_valid     <= 1'b1;
        illegal          <= single_ill_p0;
      end
    end else if (div_done_p1) begin
      Execution_Result <= div_res_p1;
      Result_valid     <= 1'b1;
      illegal          <= 1'b0;
    end else begin
      if ((state_q == S_DIV) && !system_stall) cnt_q <= cnt_q + CNT_W'(1);
      if (Result_valid && result_ready && !system_stall) Result_valid <= 1'b0;
    end
  end

  // Divider datapath: load magnitudes and sign flags on accept, then one bit per cycle.
  always_ff @(posedge clk) begin
    if (accept_p0 && start_div_p0) begin
      rem_p1    <= '0;
      quo_p1    <= apply_sign(data_src1, div_signed_p0 & data_src1[DATA_WIDTH-1]);
      dvsr_p1   <= apply_sign(opb_p0, div_signed_p0 & opb_p0[DATA_WIDTH-1]);
      neg_q_p1  <= div_signed_p0 & (data_src1[DATA_WIDTH-1] ^ opb_p0[DATA_WIDTH-1]);
      neg_r_p1  <= div_signed_p0 & data_src1[DATA_WIDTH-1];
      is_rem_p1 <= funct3[1];
    end else if ((state_q == S_DIV) && !system_stall) begin
      rem_p1 <= rem_nx_p1;
      quo_p1 <= quo_nx_p1;
    end
  end

endmodule

// File: tb/tb_execution_unit_pipe.sv
// Testbench for execution_unit_pipe: directed vector table, hand-written
// flow-control/stall/reset sequences, and random ops against a reference model.
module tb_execution_unit_pipe;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, system_stall;
  logic        Result_valid, result_ready, illegal, busy;
  logic [6:0]  instruction_type, funct7;
  logic [2:0]  funct3;
  logic [20:0] immediate;
  logic [31:0] data_src1, data_src2, Execution_Result;

  int checks = 0;
  int errors = 0;

  execution_unit_pipe #(.DATA_WIDTH(32), .SHAMT_WIDTH(5), .IMM_WIDTH(21)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_type(instruction_type), .funct3(funct3), .funct7(funct7),
    .immediate(immediate), .data_src1(data_src1), .data_src2(data_src2),
    .system_stall(system_stall), .Execution_Result(Execution_Result),
    .Result_valid(Result_valid), .result_ready(result_ready),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [20:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: instruction semantics with plain integer arithmetic.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [20:0] imm, input logic [31:0] a, input logic [31:0] src2);
    exp_t        e;
    logic [31:0] b;
    logic [4:0]  sh;
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    logic        sgn;
    e.res = 32'h0; e.ill = 1'b1; e.lat = 0;
    b  = (op == OP_I) ? {{11{imm[20]}}, imm} : src2;
    sh = b[4:0];
    sa = $signed(a);
    sb = $signed(b);
    if (op == OP_I || (op == OP_R && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))) begin
      e.ill = 1'b0;
      case (f3)
        3'd0: e.res = (op == OP_R && f7 == 7'h20) ? a - b : a + b;
        3'd1: e.res = a << sh;
        3'd2: e.res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
        3'd4: e.res = a ^ b;
        3'd5: begin
          if ((op == OP_R && f7 == 7'h20) || (op == OP_I && imm[10])) e.res = 32'(sa >>> sh);
          else e.res = a >> sh;
        end
        3'd6: e.res = a | b;
        default: e.res = a & b;
      endcase
    end else if (op == OP_R && f7 == 7'h01) begin
      e.ill = 1'b0;
      case (f3)
        3'd0: begin sp = longint'(sa) * longint'(sb); e.res = sp[31:0]; end
        3'd1: begin sp = longint'(sa) * longint'(sb); e.res = sp[63:32]; end
        3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); e.res = sp[63:32]; end
        3'd3: begin up = {32'h0, a} * {32'h0, b}; e.res = up[63:32]; end
        default: begin
          sgn = !f3[0];
          if (b == 32'h0) e.res = f3[1] ? a : 32'hFFFFFFFF;
          else if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) e.res = f3[1] ? 32'h0 : a;
          else begin
            e.lat = 32;
            if (sgn) e.res = f3[1] ? 32'(sa % sb) : 32'(sa / sb);
            else     e.res = f3[1] ? a % b : a / b;
          end
        end
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic present(input vec_t v);
    instruction_type = v.op; funct3 = v.f3; funct7 = v.f7;
    immediate = v.imm; data_src1 = v.a; data_src2 = v.b;
  endtask

  // Present an op and clock it in; returns #1 after the accept edge.
  task automatic issue(input vec_t v);
    int n = 0;
    present(v);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check({v.name, " accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after accept until Result_valid; optional stall window.
  task automatic wait_valid(input int sfrom, input int slen, input string name, output int lat);
    lat = 0;
    while (!Result_valid && lat < 200) begin
      system_stall = (lat >= sfrom) && (lat < sfrom + slen);
      #1;
      check({name, " busy"}, 32'(busy), 32'd1);
      check({name, " in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    system_stall = 1'b0;
    if (!Result_valid) check({name, " valid"}, 32'(Result_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    result_ready = 1'b1;
    issue(v);
    wait_valid(-1, 0, v.name, lat);
    check({v.name, " result"}, Execution_Result, v.res);
    check({v.name, " illegal"}, 32'(illegal), 32'(v.ill));
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v, v2;
    exp_t e;
    int   lat;
    reset = 1'b0; in_valid = 1'b0; result_ready = 1'b1; system_stall = 1'b0;
    instruction_type = 7'h0; funct3 = 3'h0; funct7 = 7'h0; immediate = 21'h0;
    data_src1 = 32'h0; data_src2 = 32'h0;

    tbl.push_back('{"ADD",    OP_R,  3'd0, 7'h00, 21'h0,      32'h10,       32'h20,       32'h00000030, 1'b0, 0});
    tbl.push_back('{"SUB",    OP_R,  3'd0, 7'h20, 21'h0,      32'h30,       32'h10,       32'h00000020, 1'b0, 0});
    tbl.push_back('{"AND",    OP_R,  3'd7, 7'h00, 21'h0,      32'hFFFFFFF0, 32'h0F0F0F0F, 32'h0F0F0F00, 1'b0, 0});
    tbl.push_back('{"XOR",    OP_R,  3'd4, 7'h00, 21'h0,      32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 0});
    tbl.push_back('{"SRAI",   OP_I,  3'd5, 7'h20, 21'h404,    32'h80000000, 32'h0,        32'hF8000000, 1'b0, 0});
    tbl.push_back('{"SRLI",   OP_I,  3'd5, 7'h00, 21'h004,    32'h80000000, 32'h0,        32'h08000000, 1'b0, 0});
    tbl.push_back('{"SLT",    OP_R,  3'd2, 7'h00, 21'h0,      32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0, 0});
    tbl.push_back('{"SLTU",   OP_R,  3'd3, 7'h00, 21'h0,      32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0, 0});
    tbl.push_back('{"ADDI-1", OP_I,  3'd0, 7'h7F, 21'h1FFFFF, 32'h5,        32'h0,        32'h00000004, 1'b0, 0});
    tbl.push_back('{"MULH",   OP_R,  3'd1, 7'h01, 21'h0,      32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 0});
    tbl.push_back('{"MULHU",  OP_R,  3'd3, 7'h01, 21'h0,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0});
    tbl.push_back('{"MULHSU", OP_R,  3'd2, 7'h01, 21'h0,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0});
    tbl.push_back('{"MUL",    OP_R,  3'd0, 7'h01, 21'h0,      32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 0});
    tbl.push_back('{"DIV",    OP_R,  3'd4, 7'h01, 21'h0,      32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 32});
    tbl.push_back('{"REM",    OP_R,  3'd6, 7'h01, 21'h0,      32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 32});
    tbl.push_back('{"DIVU",   OP_R,  3'd5, 7'h01, 21'h0,      32'd100,      32'd7,        32'd14,       1'b0, 32});
    tbl.push_back('{"REMU",   OP_R,  3'd7, 7'h01, 21'h0,      32'd100,      32'd7,        32'd2,        1'b0, 32});
    tbl.push_back('{"DIVU/0", OP_R,  3'd5, 7'h01, 21'h0,      32'h5,        32'h0,        32'hFFFFFFFF, 1'b0, 0});
    tbl.push_back('{"REMovf", OP_R,  3'd6, 7'h01, 21'h0,      32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0});
    tbl.push_back('{"LOAD",   OP_LD, 3'd2, 7'h00, 21'h0,      32'h1234,     32'h5678,     32'h00000000, 1'b1, 0});
    tbl.push_back('{"SLLalt", OP_R,  3'd1, 7'h20, 21'h0,      32'h1,        32'h1,        32'h00000000, 1'b1, 0});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset result", Execution_Result, 32'h0);
    check("reset valid", 32'(Result_valid), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b1;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Directed table
    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back single-cycle ops, one per cycle
    result_ready = 1'b1;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      v = tbl[0];
      v.name = "b2b";
      v.a = 32'(j * 100);
      present(v);
      #1;
      check("b2b in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("b2b result", Execution_Result, 32'(j * 100 + 32));
      check("b2b valid", 32'(Result_valid), 32'd1);
    end
    in_valid = 1'b0;

    // Backpressure: result and illegal hold, no acceptance
    v = tbl[0]; v.name = "bp"; v.a = 32'h1; v.b = 32'h2;
    issue(v);
    result_ready = 1'b0;
    v2 = tbl[0]; v2.a = 32'h5; v2.b = 32'h5;
    present(v2);
    in_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("bp valid", 32'(Result_valid), 32'd1);
      check("bp result", Execution_Result, 32'h3);
      check("bp illegal", 32'(illegal), 32'd0);
      check("bp in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp next result", Execution_Result, 32'hA);

    // Stall five cycles mid-divide
    issue(tbl[13]);
    wait_valid(10, 5, "stall div", lat);
    check("stall div latency", 32'(lat), 32'd37);
    check("stall div result", Execution_Result, 32'hFFFFFFFD);

    // Reset at iteration 10 of a divide
    v = tbl[0]; v.a = 32'h3; v.b = 32'h4; v.res = 32'h7; v.name = "pre-reset add";
    run_vec(v);
    issue(tbl[13]);
    repeat (10) begin @(posedge clk); #1; end
    check("mid-div busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("async reset result", Execution_Result, 32'h0);
    check("async reset valid", 32'(Result_valid), 32'd0);
    check("async reset illegal", 32'(illegal), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    v.name = "post-reset add";
    run_vec(v);

    // Random ops against the reference model
    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 9);
      v.name = "rand";
      v.imm = 21'($urandom);
      v.a = pick();
      v.b = pick();
      v.f3 = 3'($urandom);
      case (k)
        0, 1, 2: begin v.op = OP_R; v.f7 = 7'h00; end
        3:       begin v.op = OP_R; v.f7 = 7'h20; v.f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5; end
        4, 5:    begin v.op = OP_I; v.f7 = v.imm[11:5]; end
        6, 7, 8: begin v.op = OP_R; v.f7 = 7'h01; end
        default: begin
          case ($urandom_range(0, 2))
            0:       begin v.op = OP_LD; v.f7 = 7'h00; end
            1:       begin v.op = OP_R;  v.f7 = 7'h40; end
            default: begin v.op = OP_R;  v.f7 = 7'h20; v.f3 = 3'd1; end
          endcase
        end
      endcase
      e = model(v.op, v.f3, v.f7, v.imm, v.a, v.b);
      v.res = e.res; v.ill = e.ill; v.lat = e.lat;
      run_vec(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
